// File: rtl/exe_mem_fwd_pipe.sv
// ----------------------------------------------------------------------------
// exe_mem_fwd_pipe
//
// This module holds the pipeline registers that carry each instruction's
// register-write descriptor through the EXE, MEM and WB stages. It supplies
// the exe_* and mem_* forwarding descriptors to the DE hazard logic. It turns
// a load-use stall into a bubble in EXE. It also drives the register-file
// write port and keeps stall and retire event counters.
//
// Stage registers: _p0 = EXE, _p1 = MEM, _p2 = WB.
//
// Ports:
//   clk, resetn      clock and synchronous active-low reset
//   stall            load-use stall from DE; DE holds its instruction
//   de_valid         DE holds a real instruction
//   de_reg_en        DE instruction writes a GPR
//   de_reg_waddr     DE instruction destination GPR
//   de_mem_read      DE instruction is a load
//   exe_alu_result   ALU result of the instruction in EXE (combinational)
//   mem_rdata        data-memory read data of the load in MEM
//   exe_reg_*        EXE write descriptor and forward data
//   exe_mem_read     EXE instruction is a load
//   mem_reg_*        MEM write descriptor and forward data
//   wb_reg_*         register-file write port
//   stall_cnt        cycles lost to load-use stalls
//   retire_cnt       instructions that left WB valid
// ----------------------------------------------------------------------------
module exe_mem_fwd_pipe (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        de_valid,
    input  logic        de_reg_en,
    input  logic [4:0]  de_reg_waddr,
    input  logic        de_mem_read,
    input  logic [31:0] exe_alu_result,
    input  logic [31:0] mem_rdata,
    output logic        exe_reg_en,
    output logic [4:0]  exe_reg_waddr,
    output logic [31:0] exe_reg_wdata,
    output logic        exe_mem_read,
    output logic        mem_reg_en,
    output logic [4:0]  mem_reg_waddr,
    output logic [31:0] mem_reg_wdata,
    output logic        wb_reg_en,
    output logic [4:0]  wb_reg_waddr,
    output logic [31:0] wb_reg_wdata,
    output logic [31:0] stall_cnt,
    output logic [31:0] retire_cnt
);

    logic        accept;
    logic        de_wen;

    logic        vld_p0;
    logic        wen_p0;
    logic [4:0]  waddr_p0;
    logic        rd_p0;

    logic        vld_p1;
    logic        wen_p1;
    logic [4:0]  waddr_p1;
    logic        rd_p1;
    logic [31:0] alu_p1;

    logic        vld_p2;
    logic        wen_p2;
    logic [4:0]  waddr_p2;
    logic [31:0] wdata_p2;

    assign accept = de_valid & ~stall;
    // A write to $0 is dropped at the door, so no stage ever shows it enabled.
    assign de_wen = de_reg_en & (de_reg_waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p0     <= 1'b0;
            wen_p0     <= 1'b0;
            waddr_p0   <= 5'd0;
            rd_p0      <= 1'b0;
            vld_p1     <= 1'b0;
            wen_p1     <= 1'b0;
            waddr_p1   <= 5'd0;
            rd_p1      <= 1'b0;
            alu_p1     <= 32'd0;
            vld_p2     <= 1'b0;
            wen_p2     <= 1'b0;
            waddr_p2   <= 5'd0;
            wdata_p2   <= 32'd0;
            stall_cnt  <= 32'd0;
            retire_cnt <= 32'd0;
        end else begin
            // DE -> EXE: a stall or an empty DE loads a bubble.
            vld_p0   <= accept;
            wen_p0   <= accept & de_wen;
            waddr_p0 <= (accept & de_wen) ? de_reg_waddr : 5'd0;
            rd_p0    <= accept & de_mem_read;

            // EXE -> MEM
            vld_p1   <= vld_p0;
            wen_p1   <= wen_p0;
            waddr_p1 <= waddr_p0;
            rd_p1    <= rd_p0;
            alu_p1   <= exe_alu_result;

            // MEM -> WB
            vld_p2   <= vld_p1;
            wen_p2   <= wen_p1;
            waddr_p2 <= waddr_p1;
            wdata_p2 <= mem_reg_wdata;

            if (stall && de_valid) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (vld_p2) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    // Bubbles always carry wen=0 and mem_read=0. The valid qualification is
    // therefore already in the stored bit, and these outputs come directly
    // from flops.
    assign exe_reg_en    = wen_p0;
    assign exe_reg_waddr = waddr_p0;
    assign exe_reg_wdata = exe_alu_result;
    assign exe_mem_read  = rd_p0;

    assign mem_reg_en    = wen_p1;
    assign mem_reg_waddr = waddr_p1;
    assign mem_reg_wdata = rd_p1 ? mem_rdata : alu_p1;

    assign wb_reg_en     = wen_p2;
    assign wb_reg_waddr  = waddr_p2;
    assign wb_reg_wdata  = wdata_p2;

    // vld_p1 is kept for stage symmetry; only WB validity feeds a counter.
    logic unused_ok;
    assign unused_ok = vld_p1;

endmodule

// File: tb/tb_exe_mem_fwd_pipe.sv
module tb_exe_mem_fwd_pipe;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        de_valid;
    logic        de_reg_en;
    logic [4:0]  de_reg_waddr;
    logic        de_mem_read;
    logic [31:0] exe_alu_result;
    logic [31:0] mem_rdata;
    logic        exe_reg_en;
    logic [4:0]  exe_reg_waddr;
    logic [31:0] exe_reg_wdata;
    logic        exe_mem_read;
    logic        mem_reg_en;
    logic [4:0]  mem_reg_waddr;
    logic [31:0] mem_reg_wdata;
    logic        wb_reg_en;
    logic [4:0]  wb_reg_waddr;
    logic [31:0] wb_reg_wdata;
    logic [31:0] stall_cnt;
    logic [31:0] retire_cnt;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    exe_mem_fwd_pipe dut (
        .clk(clk), .resetn(resetn), .stall(stall), .de_valid(de_valid),
        .de_reg_en(de_reg_en), .de_reg_waddr(de_reg_waddr), .de_mem_read(de_mem_read),
        .exe_alu_result(exe_alu_result), .mem_rdata(mem_rdata),
        .exe_reg_en(exe_reg_en), .exe_reg_waddr(exe_reg_waddr),
        .exe_reg_wdata(exe_reg_wdata), .exe_mem_read(exe_mem_read),
        .mem_reg_en(mem_reg_en), .mem_reg_waddr(mem_reg_waddr),
        .mem_reg_wdata(mem_reg_wdata),
        .wb_reg_en(wb_reg_en), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
        .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall        = 1'b0;
        de_valid     = 1'b0;
        de_reg_en    = 1'b0;
        de_reg_waddr = 5'd0;
        de_mem_read  = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall          = 1'($urandom);
            de_valid       = 1'($urandom);
            de_reg_en      = 1'($urandom);
            de_reg_waddr   = 5'($urandom);
            de_mem_read    = 1'($urandom);
            exe_alu_result = $urandom;
            mem_rdata      = $urandom;
            tick();
        end
        ntot++; if ({exe_reg_en, exe_reg_waddr, exe_mem_read} !== 7'd0)
            $display("FAIL reset_exe got %b expected 0", {exe_reg_en, exe_reg_waddr, exe_mem_read}); else npass++;
        ntot++; if ({mem_reg_en, mem_reg_waddr, mem_reg_wdata} !== 38'd0)
            $display("FAIL reset_mem got %h expected 0", {mem_reg_en, mem_reg_waddr, mem_reg_wdata}); else npass++;
        ntot++; if ({wb_reg_en, wb_reg_waddr, wb_reg_wdata} !== 38'd0)
            $display("FAIL reset_wb got %h expected 0", {wb_reg_en, wb_reg_waddr, wb_reg_wdata}); else npass++;
        ntot++; if (stall_cnt !== 32'd0 || retire_cnt !== 32'd0)
            $display("FAIL reset_cnt got %h/%h expected 0/0", stall_cnt, retire_cnt); else npass++;
        exe_alu_result = 32'h1234_5678;
        #1;
        ntot++; if (exe_reg_wdata !== 32'h1234_5678)
            $display("FAIL reset_exe_wdata got %h expected 12345678", exe_reg_wdata); else npass++;
        idle_inputs();
        mem_rdata = 32'hBAD0_BAD0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_alu_chain();
        de_valid = 1'b1; de_reg_en = 1'b1; de_reg_waddr = 5'd3; de_mem_read = 1'b0;
        tick();
        exe_alu_result = 32'h11;
        de_reg_waddr = 5'd4;
        #1;
        ntot++; if (exe_reg_en !== 1'b1 || exe_reg_waddr !== 5'd3 || exe_reg_wdata !== 32'h11)
            $display("FAIL alu_exe got en=%b wa=%0d wd=%h expected 1/3/11", exe_reg_en, exe_reg_waddr, exe_reg_wdata); else npass++;
        tick();
        de_valid = 1'b0;
        exe_alu_result = 32'h22;
        #1;
        ntot++; if (mem_reg_en !== 1'b1 || mem_reg_waddr !== 5'd3 || mem_reg_wdata !== 32'h11)
            $display("FAIL alu_mem got en=%b wa=%0d wd=%h expected 1/3/11", mem_reg_en, mem_reg_waddr, mem_reg_wdata); else npass++;
        ntot++; if (exe_reg_en !== 1'b1 || exe_reg_waddr !== 5'd4)
            $display("FAIL alu_exe2 got en=%b wa=%0d expected 1/4", exe_reg_en, exe_reg_waddr); else npass++;
        tick();
        exe_alu_result = 32'h0;
        ntot++; if (wb_reg_en !== 1'b1 || wb_reg_waddr !== 5'd3 || wb_reg_wdata !== 32'h11)
            $display("FAIL alu_wb got en=%b wa=%0d wd=%h expected 1/3/11", wb_reg_en, wb_reg_waddr, wb_reg_wdata); else npass++;
        ntot++; if (mem_reg_waddr !== 5'd4 || mem_reg_wdata !== 32'h22)
            $display("FAIL alu_mem2 got wa=%0d wd=%h expected 4/22", mem_reg_waddr, mem_reg_wdata); else npass++;
        ntot++; if (exe_reg_en !== 1'b0)
            $display("FAIL alu_exe_bubble got %b expected 0", exe_reg_en); else npass++;
        tick();
        ntot++; if (retire_cnt !== 32'd1 || wb_reg_waddr !== 5'd4 || wb_reg_wdata !== 32'h22)
            $display("FAIL alu_commit got rc=%0d wa=%0d wd=%h expected 1/4/22", retire_cnt, wb_reg_waddr, wb_reg_wdata); else npass++;
        tick();
        ntot++; if (retire_cnt !== 32'd2 || wb_reg_en !== 1'b0)
            $display("FAIL alu_drain got rc=%0d wben=%b expected 2/0", retire_cnt, wb_reg_en); else npass++;
    endtask

    task automatic test_load_use();
        de_valid = 1'b1; de_reg_en = 1'b1; de_reg_waddr = 5'd5; de_mem_read = 1'b1;
        tick();
        exe_alu_result = 32'h100;
        de_reg_waddr = 5'd6; de_mem_read = 1'b0; stall = 1'b1;
        #1;
        ntot++; if (exe_mem_read !== 1'b1 || exe_reg_en !== 1'b1 || exe_reg_waddr !== 5'd5)
            $display("FAIL ld_exe got rd=%b en=%b wa=%0d expected 1/1/5", exe_mem_read, exe_reg_en, exe_reg_waddr); else npass++;
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        stall = 1'b0;
        exe_alu_result = 32'h0;
        #1;
        ntot++; if (exe_reg_en !== 1'b0 || exe_mem_read !== 1'b0)
            $display("FAIL ld_bubble got en=%b rd=%b expected 0/0", exe_reg_en, exe_mem_read); else npass++;
        ntot++; if (mem_reg_en !== 1'b1 || mem_reg_waddr !== 5'd5 || mem_reg_wdata !== 32'hDEAD_BEEF)
            $display("FAIL ld_mem got en=%b wa=%0d wd=%h expected 1/5/deadbeef", mem_reg_en, mem_reg_waddr, mem_reg_wdata); else npass++;
        ntot++; if (stall_cnt !== 32'd1)
            $display("FAIL ld_stall_cnt got %0d expected 1", stall_cnt); else npass++;
        tick();
        de_valid = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        exe_alu_result = 32'h77;
        #1;
        ntot++; if (exe_reg_en !== 1'b1 || exe_reg_waddr !== 5'd6)
            $display("FAIL ld_dep_exe got en=%b wa=%0d expected 1/6", exe_reg_en, exe_reg_waddr); else npass++;
        ntot++; if (wb_reg_en !== 1'b1 || wb_reg_waddr !== 5'd5 || wb_reg_wdata !== 32'hDEAD_BEEF)
            $display("FAIL ld_wb got en=%b wa=%0d wd=%h expected 1/5/deadbeef", wb_reg_en, wb_reg_waddr, wb_reg_wdata); else npass++;
        ntot++; if (mem_reg_en !== 1'b0 || stall_cnt !== 32'd1)
            $display("FAIL ld_bubble_mem got en=%b sc=%0d expected 0/1", mem_reg_en, stall_cnt); else npass++;
        for (int i = 0; i < 3; i++) tick();
        ntot++; if (retire_cnt !== 32'd4)
            $display("FAIL ld_retire got %0d expected 4", retire_cnt); else npass++;
    endtask

    task automatic test_zero_reg();
        de_valid = 1'b1; de_reg_en = 1'b1; de_reg_waddr = 5'd0; de_mem_read = 1'b0;
        tick();
        de_valid = 1'b0;
        ntot++; if (exe_reg_en !== 1'b0 || exe_reg_waddr !== 5'd0)
            $display("FAIL zero_exe got en=%b wa=%0d expected 0/0", exe_reg_en, exe_reg_waddr); else npass++;
        tick();
        ntot++; if (mem_reg_en !== 1'b0 || mem_reg_waddr !== 5'd0)
            $display("FAIL zero_mem got en=%b wa=%0d expected 0/0", mem_reg_en, mem_reg_waddr); else npass++;
        tick();
        ntot++; if (wb_reg_en !== 1'b0 || wb_reg_waddr !== 5'd0)
            $display("FAIL zero_wb got en=%b wa=%0d expected 0/0", wb_reg_en, wb_reg_waddr); else npass++;
        tick();
        ntot++; if (retire_cnt !== 32'd5)
            $display("FAIL zero_retire got %0d expected 5", retire_cnt); else npass++;
        stall = 1'b1; de_valid = 1'b0;
        tick();
        stall = 1'b0;
        ntot++; if (stall_cnt !== 32'd1 || exe_reg_en !== 1'b0)
            $display("FAIL stall_idle got sc=%0d en=%b expected 1/0", stall_cnt, exe_reg_en); else npass++;
    endtask

    task automatic test_midflight_reset();
        int wb_seen;
        de_valid = 1'b1; de_reg_en = 1'b1; de_mem_read = 1'b0;
        de_reg_waddr = 5'd7; tick();
        de_reg_waddr = 5'd8; tick();
        de_reg_waddr = 5'd9; tick();
        de_valid = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        ntot++; if (stall_cnt !== 32'd0 || retire_cnt !== 32'd0)
            $display("FAIL mid_rst_cnt got %0d/%0d expected 0/0", stall_cnt, retire_cnt); else npass++;
        wb_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (wb_reg_en !== 1'b0 || mem_reg_en !== 1'b0 || exe_reg_en !== 1'b0) wb_seen++;
            tick();
        end
        ntot++; if (wb_seen != 0)
            $display("FAIL mid_rst_write got %0d enabled cycles expected 0", wb_seen); else npass++;
        ntot++; if (retire_cnt !== 32'd0)
            $display("FAIL mid_rst_retire got %0d expected 0", retire_cnt); else npass++;
    endtask

    task automatic test_counter_wrap();
        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt;
        stall = 1'b1; de_valid = 1'b1;
        tick();
        stall = 1'b0; de_valid = 1'b0;
        ntot++; if (stall_cnt !== 32'd0)
            $display("FAIL stall_wrap got %h expected 0", stall_cnt); else npass++;
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        exe_alu_result = 32'd0;
        mem_rdata = 32'd0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_zero_reg();
        test_midflight_reset();
        test_counter_wrap();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
